fifo_dedup_writer: RTL and testbench

FIFO_DEDUP_WRITER -- requirements
Module: fifo_dedup_writer

---
 rtl/fifo_dedup_pkg.sv | 21 ++
 rtl/fifo_dedup_sat_counter.sv | 34 +++
 rtl/fifo_dedup_writer.sv | 128 ++++++++++++
 tb/tb_fifo_dedup_writer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_dedup_pkg.sv
// Shared definitions for the deduplicating FIFO writer: state encoding,
// parameter defaults and counter sizing.
package fifo_dedup_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_CHECK_TIMEOUT = 20;
    localparam int DROP_CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CHECK_REQ  = 2'd1,
        ST_CHECK_WAIT = 2'd2,
        ST_WRITE      = 2'd3
    } state_t;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_dedup_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_dedup_writer.sv
// Writes each accepted stream item into a FIFO unless a content search
// reports that the FIFO already holds it.
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | ready for a new item
// CHECK_REQ   | one-cycle search request carrying the held item
// CHECK_WAIT  | waiting for the search result (first cycle is blanked)
// WRITE       | writing the held item, stalled while the FIFO is full
module fifo_dedup_writer
    import fifo_dedup_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CHECK_TIMEOUT = DEF_CHECK_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    input  logic [DATA_WIDTH-1:0]     in_dat,
    output logic                      in_rdy,
    output logic                      fifo_wren,
    output logic [DATA_WIDTH-1:0]     fifo_wdat,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    output logic                      fifo_check_req,
    output logic [DATA_WIDTH-1:0]     fifo_check_dat,
    input  logic                      fifo_check_res,
    input  logic                      fifo_check_vld,
    output logic                      wr_pulse,
    output logic                      drop_pulse,
    output logic                      timeout_pulse,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    output logic                      busy
);

    localparam int            TW        = cnt_width(CHECK_TIMEOUT);
    localparam logic [TW-1:0] WAIT_LAST = TW'(CHECK_TIMEOUT - 1);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   item_q;
    logic [TW-1:0]           wait_cnt_q;
    logic                    drop_pulse_q;
    logic                    timeout_pulse_q;

    logic accept;
    logic in_check_wait;
    logic res_qual;
    logic dup_hit;
    logic wait_expired;

    // in_rdy is gated by rst so it is low throughout reset and high as soon as it lifts.
    assign in_rdy        = rst && (state_q == ST_IDLE);
    assign accept        = in_rdy && in_vld;
    assign in_check_wait = (state_q == ST_CHECK_WAIT);

    // wait_cnt_q == 0 marks the blanking cycle, where the search result is stale.
    assign res_qual      = in_check_wait && fifo_check_vld && (wait_cnt_q != '0);
    assign dup_hit       = res_qual && fifo_check_res;
    assign wait_expired  = in_check_wait && !res_qual && (wait_cnt_q == WAIT_LAST);

    assign fifo_wren      = (state_q == ST_WRITE) && !fifo_full;
    assign fifo_wdat      = fifo_wren ? item_q : '0;
    assign fifo_check_req = (state_q == ST_CHECK_REQ);
    assign fifo_check_dat = fifo_check_req ? item_q : '0;
    assign wr_pulse       = fifo_wren;
    assign drop_pulse     = drop_pulse_q;
    assign timeout_pulse  = timeout_pulse_q;
    assign busy           = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            item_q          <= '0;
            wait_cnt_q      <= '0;
            drop_pulse_q    <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            drop_pulse_q    <= 1'b0;
            timeout_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        item_q  <= in_dat;
                        state_q <= fifo_empty ? ST_WRITE : ST_CHECK_REQ;
                    end
                end
                ST_CHECK_REQ: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_CHECK_WAIT;
                end
                ST_CHECK_WAIT: begin
                    if (res_qual) begin
                        if (fifo_check_res) begin
                            drop_pulse_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            state_q      <= ST_WRITE;
                        end
                    end else if (wait_expired) begin
                        timeout_pulse_q <= 1'b1;
                        state_q         <= ST_WRITE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!fifo_full) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (DROP_CNT_WIDTH)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (dup_hit),
        .clr_i (1'b0),
        .cnt_o (drop_cnt)
    );

endmodule

// File: tb/tb_fifo_dedup_writer.sv
// Directed scenarios plus a randomized run against a set-based model of
// which items the FIFO should end up holding.
module tb_fifo_dedup_writer;

    localparam int DW = 32;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic [DW-1:0] in_dat;
    logic          in_rdy;
    logic          fifo_wren;
    logic [DW-1:0] fifo_wdat;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_check_req;
    logic [DW-1:0] fifo_check_dat;
    logic          fifo_check_res;
    logic          fifo_check_vld;
    logic          wr_pulse;
    logic          drop_pulse;
    logic          timeout_pulse;
    logic [15:0]   drop_cnt;
    logic          busy;

    int checks = 0;
    int errors = 0;

    fifo_dedup_writer #(
        .DATA_WIDTH    (DW),
        .CHECK_TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_vld         (in_vld),
        .in_dat         (in_dat),
        .in_rdy         (in_rdy),
        .fifo_wren      (fifo_wren),
        .fifo_wdat      (fifo_wdat),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_check_req (fifo_check_req),
        .fifo_check_dat (fifo_check_dat),
        .fifo_check_res (fifo_check_res),
        .fifo_check_vld (fifo_check_vld),
        .wr_pulse       (wr_pulse),
        .drop_pulse     (drop_pulse),
        .timeout_pulse  (timeout_pulse),
        .drop_cnt       (drop_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [86:0] all_outs();
        return {in_rdy, fifo_wren, fifo_wdat, fifo_check_req, fifo_check_dat,
                wr_pulse, drop_pulse, timeout_pulse, drop_cnt, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_vld         = 1'b0;
        in_dat         = '0;
        fifo_full      = 1'b0;
        fifo_empty     = 1'b1;
        fifo_check_res = 1'b0;
        fifo_check_vld = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs actual=%h required=0", all_outs());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy actual=%b required=1", in_rdy);
        end
        step();
    endtask

    task automatic test_bypass();
        idle_inputs();
        fifo_empty = 1'b1;
        in_vld     = 1'b1;
        in_dat     = 32'h0000_00A5;
        step();
        in_vld = 1'b0;
        checks++;
        if ({fifo_wren, wr_pulse, fifo_check_req} !== 3'b110 || fifo_wdat !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL bypass_write actual=wren%b pulse%b req%b dat%h required=wren1 pulse1 req0 dat000000a5",
                     fifo_wren, wr_pulse, fifo_check_req, fifo_wdat);
        end
        step();
        checks++;
        if ({fifo_wren, busy, in_rdy} !== 3'b001) begin
            errors++;
            $display("FAIL bypass_after actual=wren%b busy%b rdy%b required=wren0 busy0 rdy1",
                     fifo_wren, busy, in_rdy);
        end
    endtask

    task automatic test_dup_drop();
        int reqs  = 0;
        int wrens = 0;
        idle_inputs();
        fifo_empty = 1'b0;
        in_vld     = 1'b1;
        in_dat     = 32'h11;
        step();                                 // cycle N+1
        in_vld = 1'b0;
        checks++;
        if (fifo_check_req !== 1'b1 || fifo_check_dat !== 32'h11) begin
            errors++;
            $display("FAIL dup_req actual=req%b dat%h required=req1 dat00000011",
                     fifo_check_req, fifo_check_dat);
        end
        reqs  += int'(fifo_check_req);
        wrens += int'(fifo_wren);
        step();                                 // cycle N+2
        checks++;
        if (fifo_check_dat !== '0) begin
            errors++;
            $display("FAIL dup_chkdat_idle actual=%h required=0", fifo_check_dat);
        end
        reqs  += int'(fifo_check_req);
        wrens += int'(fifo_wren);
        step();                                 // cycle N+3
        reqs  += int'(fifo_check_req);
        wrens += int'(fifo_wren);
        fifo_check_vld = 1'b1;
        fifo_check_res = 1'b1;
        step();                                 // cycle N+4
        fifo_check_vld = 1'b0;
        fifo_check_res = 1'b0;
        #1;
        reqs  += int'(fifo_check_req);
        wrens += int'(fifo_wren);
        checks++;
        if (drop_pulse !== 1'b1 || drop_cnt !== 16'd1 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL dup_drop actual=pulse%b cnt%0d rdy%b required=pulse1 cnt1 rdy1",
                     drop_pulse, drop_cnt, in_rdy);
        end
        step();
        wrens += int'(fifo_wren);
        checks++;
        if (reqs != 1 || wrens != 0 || drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL dup_counts actual=reqs%0d wrens%0d pulse%b required=reqs1 wrens0 pulse0",
                     reqs, wrens, drop_pulse);
        end
    endtask

    task automatic test_blanking();
        idle_inputs();
        fifo_empty = 1'b0;
        in_vld     = 1'b1;
        in_dat     = 32'h22;
        step();                                 // N+1
        in_vld = 1'b0;
        step();                                 // N+2: blanking cycle
        fifo_check_vld = 1'b1;
        fifo_check_res = 1'b1;
        step();                                 // N+3
        fifo_check_vld = 1'b0;
        fifo_check_res = 1'b0;
        #1;
        checks++;
        if ({drop_pulse, busy, fifo_wren} !== 3'b010) begin
            errors++;
            $display("FAIL blank_ignored actual=drop%b busy%b wren%b required=drop0 busy1 wren0",
                     drop_pulse, busy, fifo_wren);
        end
        step();                                 // N+4
        fifo_check_vld = 1'b1;
        fifo_check_res = 1'b0;
        step();                                 // N+5
        fifo_check_vld = 1'b0;
        #1;
        checks++;
        if (fifo_wren !== 1'b1 || fifo_wdat !== 32'h22 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL blank_write actual=wren%b dat%h cnt%0d required=wren1 dat00000022 cnt1",
                     fifo_wren, fifo_wdat, drop_cnt);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL blank_idle actual=%b required=0", busy);
        end
    endtask

    task automatic test_timeout();
        int tp_cyc = -1;
        int wr_cyc = -1;
        int wrens  = 0;
        idle_inputs();
        fifo_empty = 1'b0;
        in_vld     = 1'b1;
        in_dat     = 32'h33;
        step();
        in_vld = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (timeout_pulse === 1'b1 && tp_cyc < 0) tp_cyc = k;
            if (fifo_wren === 1'b1) begin
                wrens++;
                wr_cyc = k;
                checks++;
                if (fifo_wdat !== 32'h33) begin
                    errors++;
                    $display("FAIL timeout_wdat actual=%h required=00000033", fifo_wdat);
                end
            end
            step();
        end
        checks++;
        if (tp_cyc != TO + 2 || wr_cyc != TO + 2 || wrens != 1) begin
            errors++;
            $display("FAIL timeout_timing actual=tp%0d wr%0d n%0d required=tp%0d wr%0d n1",
                     tp_cyc, wr_cyc, wrens, TO + 2, TO + 2);
        end
    endtask

    task automatic test_full_stall();
        idle_inputs();
        fifo_empty = 1'b1;
        fifo_full  = 1'b1;
        in_vld     = 1'b1;
        in_dat     = 32'h44;
        step();
        in_vld = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if ({fifo_wren, in_rdy, fifo_wdat} !== '0) begin
                errors++;
                $display("FAIL stall_cycle%0d actual=wren%b rdy%b dat%h required=all0",
                         k, fifo_wren, in_rdy, fifo_wdat);
            end
            step();
        end
        fifo_full = 1'b0;
        #1;
        checks++;
        if (fifo_wren !== 1'b1 || fifo_wdat !== 32'h44 || in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release actual=wren%b dat%h rdy%b required=wren1 dat00000044 rdy0",
                     fifo_wren, fifo_wdat, in_rdy);
        end
        step();
        checks++;
        if (fifo_wren !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall_once actual=wren%b rdy%b required=wren0 rdy1", fifo_wren, in_rdy);
        end
    endtask

    task automatic test_reset_mid();
        int wrens = 0;
        idle_inputs();
        fifo_empty = 1'b0;
        in_vld     = 1'b1;
        in_dat     = 32'h55;
        step();
        in_vld = 1'b0;
        step();
        step();                                 // N+3: CHECK_WAIT
        rst = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL midreset_outputs actual=%h required=0", all_outs());
        end
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rdy actual=%b required=1", in_rdy);
        end
        fifo_check_vld = 1'b1;
        fifo_check_res = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            wrens += int'(fifo_wren);
        end
        fifo_check_vld = 1'b0;
        checks++;
        if (wrens != 0) begin
            errors++;
            $display("FAIL midreset_nowrite actual=%0d required=0", wrens);
        end
    endtask

    task automatic test_random();
        localparam int N = 60;
        logic [DW-1:0] fifo_q[$];
        logic [DW-1:0] exp_q[$];
        bit            seen[16];
        int            exp_drops = 0;
        int            n_acc     = 0;
        int            n_wr      = 0;
        int            n_tp      = 0;
        int            resp_cnt  = 0;
        int            resp_d    = 0;
        logic          resp_match = 1'b0;
        int            idle_run  = 0;
        int            cyc       = 0;
        int            exp_total;

        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        foreach (seen[i]) seen[i] = 1'b0;

        while (cyc < 4000 && !(n_acc >= N && idle_run >= 3)) begin
            @(negedge clk);
            fifo_check_vld = 1'b0;
            fifo_check_res = 1'($urandom_range(0, 1));
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    fifo_check_vld = 1'b1;
                    fifo_check_res = resp_match;
                end else if (resp_cnt == resp_d - 1 && $urandom_range(0, 2) == 0) begin
                    fifo_check_vld = 1'b1;
                    fifo_check_res = ~resp_match;
                end
            end
            fifo_empty = (fifo_q.size() == 0);
            fifo_full  = ($urandom_range(0, 3) == 0);
            in_vld     = (n_acc < N) && ($urandom_range(0, 1) == 1);
            in_dat     = DW'($urandom_range(0, 15));
            #1;
            if (in_vld && in_rdy) begin
                n_acc++;
                if (seen[in_dat[3:0]]) begin
                    exp_drops++;
                end else begin
                    seen[in_dat[3:0]] = 1'b1;
                    exp_q.push_back(in_dat);
                end
            end
            checks++;
            if (fifo_wren && fifo_check_req) begin
                errors++;
                $display("FAIL rand_wren_and_req cycle=%0d actual=both required=not both", cyc);
            end
            if (!fifo_wren) begin
                checks++;
                if (fifo_wdat !== '0) begin
                    errors++;
                    $display("FAIL rand_wdat_idle actual=%h required=0", fifo_wdat);
                end
            end else begin
                n_wr++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected_write actual=%h required=none", fifo_wdat);
                end else begin
                    if (fifo_wdat !== exp_q[0]) begin
                        errors++;
                        $display("FAIL rand_write_data actual=%h required=%h", fifo_wdat, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                fifo_q.push_back(fifo_wdat);
            end
            if (timeout_pulse) n_tp++;
            if (fifo_check_req) begin
                resp_d     = int'($urandom_range(2, 8));
                resp_cnt   = resp_d;
                resp_match = 1'b0;
                foreach (fifo_q[i]) if (fifo_q[i] == fifo_check_dat) resp_match = 1'b1;
            end
            if (!busy && !in_vld) idle_run++;
            else idle_run = 0;
            cyc++;
        end
        idle_inputs();

        checks++;
        if (cyc >= 4000) begin
            errors++;
            $display("FAIL rand_budget actual=%0d accepted required=%0d", n_acc, N);
        end
        exp_total = n_acc - exp_drops;
        checks++;
        if (n_wr != exp_total || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_write_count actual=%0d required=%0d", n_wr, exp_total);
        end
        checks++;
        if (drop_cnt !== 16'(exp_drops)) begin
            errors++;
            $display("FAIL rand_drop_cnt actual=%0d required=%0d", drop_cnt, exp_drops);
        end
        checks++;
        if (n_tp != 0) begin
            errors++;
            $display("FAIL rand_timeouts actual=%0d required=0", n_tp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bypass();
        test_dup_drop();
        test_blanking();
        test_timeout();
        test_full_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
